// File: rtl/rriot_bus_pkg.sv
// Shared types and idle-bus constants for the RRIOT two-master bus arbiter.
package rriot_bus_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    typedef logic mst_idx_t;

    localparam logic       IDLE_WE_N = 1'b1;
    localparam logic [9:0] IDLE_A    = 10'h000;

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-master round-robin winner select with a bounded lock for read-modify-write runs.
module rr_lock_arb2
    import rriot_bus_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       i_arb,
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    output mst_idx_t   o_win
);

    localparam int unsigned    LCW      = $clog2(MAX_LOCK + 1);
    localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

    if (MAX_LOCK < 1) begin : g_bad_max_lock
        $error("MAX_LOCK must be at least 1");
    end

    mst_idx_t       r_last;
    mst_idx_t       r_own;
    logic           r_own_vld;
    logic [LCW-1:0] r_cnt;

    logic           w_cap;
    logic           w_rule_a;
    mst_idx_t       w_win;
    logic [LCW-1:0] w_cnt_base;

    // A capped owner forfeits one arbitration; the lock then drops entirely.
    assign w_cap      = r_own_vld && (r_cnt == LOCK_MAX);
    assign w_rule_a   = r_own_vld && i_req[r_own] && !w_cap;
    assign w_cnt_base = w_rule_a ? r_cnt : '0;

    always_comb begin
        w_win = r_last;
        if (w_rule_a) begin
            w_win = r_own;
        end else if (i_req[0] && !i_req[1]) begin
            w_win = 1'b0;
        end else if (i_req[1] && !i_req[0]) begin
            w_win = 1'b1;
        end else begin
            w_win = ~r_last;
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b1;
            r_own     <= 1'b0;
            r_own_vld <= 1'b0;
            r_cnt     <= '0;
        end else if (i_arb) begin
            r_last <= w_win;
            if (i_lock[w_win]) begin
                r_own_vld <= 1'b1;
                r_own     <= w_win;
                r_cnt     <= w_cnt_base + LCW'(1);
            end else begin
                r_own_vld <= 1'b0;
                r_own     <= 1'b0;
                r_cnt     <= '0;
            end
        end
    end

    assign o_win = w_win;

endmodule

// File: rtl/rriot_bus_arbiter.sv
// Arbitrates CPU and debug masters onto the 6530 bus, sequences the access and returns an ack.
module rriot_bus_arbiter
    import rriot_bus_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 1,
    parameter int unsigned MAX_LOCK      = 4
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [9:0] m0_addr,
    input  logic       m0_rs0,
    input  logic [7:0] m0_wdata,
    input  logic       m0_lock,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [9:0] m1_addr,
    input  logic       m1_rs0,
    input  logic [7:0] m1_wdata,
    input  logic       m1_lock,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       bus_sel,
    output logic       bus_we_n,
    output logic [9:0] bus_a,
    output logic       bus_rs0,
    output logic [7:0] bus_di,
    input  logic [7:0] bus_do
);

    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
        $error("ACCESS_CYCLES must be in 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_e     r_state;
    mst_idx_t   r_win;
    logic       r_we;
    logic [3:0] r_cnt;
    logic       r_ack0;
    logic       r_ack1;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;
    logic       r_bus_sel;
    logic       r_bus_we_n;
    logic [9:0] r_bus_a;
    logic       r_bus_rs0;
    logic [7:0] r_bus_di;

    logic       w_arb;
    mst_idx_t   w_win;
    logic       w_we;
    logic [9:0] w_addr;
    logic       w_rs0;
    logic [7:0] w_wdata;

    assign w_arb = (r_state == StIdle) && (m0_req || m1_req);

    rr_lock_arb2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .phi2   (phi2),
        .rst_n  (rst_n),
        .i_arb  (w_arb),
        .i_req  ({m1_req, m0_req}),
        .i_lock ({m1_lock, m0_lock}),
        .o_win  (w_win)
    );

    assign w_we    = w_win ? m1_we    : m0_we;
    assign w_addr  = w_win ? m1_addr  : m0_addr;
    assign w_rs0   = w_win ? m1_rs0   : m0_rs0;
    assign w_wdata = w_win ? m1_wdata : m0_wdata;

    // The bus output registers double as the latched address/rs0/wdata fields.
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= 4'd0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= 8'h00;
            r_rdata1   <= 8'h00;
            r_bus_sel  <= 1'b0;
            r_bus_we_n <= IDLE_WE_N;
            r_bus_a    <= IDLE_A;
            r_bus_rs0  <= 1'b0;
            r_bus_di   <= 8'h00;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_arb) begin
                        r_state    <= StAccess;
                        r_win      <= w_win;
                        r_we       <= w_we;
                        r_cnt      <= CNT_LOAD;
                        r_bus_sel  <= 1'b1;
                        r_bus_we_n <= !w_we;
                        r_bus_a    <= w_addr;
                        r_bus_rs0  <= w_rs0;
                        r_bus_di   <= w_we ? w_wdata : 8'h00;
                    end
                end
                StAccess: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= StResp;
                        r_bus_sel  <= 1'b0;
                        r_bus_we_n <= IDLE_WE_N;
                        r_bus_a    <= IDLE_A;
                        r_bus_rs0  <= 1'b0;
                        r_bus_di   <= 8'h00;
                        if (r_win) begin
                            r_ack1 <= 1'b1;
                            if (!r_we) r_rdata1 <= bus_do;
                        end else begin
                            r_ack0 <= 1'b1;
                            if (!r_we) r_rdata0 <= bus_do;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign m0_ack   = r_ack0;
    assign m1_ack   = r_ack1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign bus_sel  = r_bus_sel;
    assign bus_we_n = r_bus_we_n;
    assign bus_a    = r_bus_a;
    assign bus_rs0  = r_bus_rs0;
    assign bus_di   = r_bus_di;

endmodule

// File: tb/tb_rriot_bus_arbiter.sv
// Directed-vector bench for rriot_bus_arbiter: one instance at ACCESS_CYCLES=1, one at 3.
module tb_rriot_bus_arbiter;

    logic       phi2;
    logic       rst_n;
    logic       m0_req, m0_we, m0_rs0, m0_lock;
    logic [9:0] m0_addr;
    logic [7:0] m0_wdata;
    logic       m1_req, m1_we, m1_rs0, m1_lock;
    logic [9:0] m1_addr;
    logic [7:0] m1_wdata;
    logic [7:0] bus_do;
    logic       m0_ack, m1_ack, bus_sel, bus_we_n, bus_rs0;
    logic [7:0] m0_rdata, m1_rdata, bus_di;
    logic [9:0] bus_a;

    logic       t_req, t_we, t_rs0;
    logic [9:0] t_addr;
    logic [7:0] t_do;
    logic       t_m0_ack, t_m1_ack, t_sel, t_we_n, t_bus_rs0;
    logic [7:0] t_m0_rdata, t_m1_rdata, t_di;
    logic [9:0] t_a;

    int n_chk;
    int n_err;

    rriot_bus_arbiter #(
        .ACCESS_CYCLES (1),
        .MAX_LOCK      (4)
    ) dut (
        .phi2     (phi2),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_rs0   (m0_rs0),
        .m0_wdata (m0_wdata),
        .m0_lock  (m0_lock),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_rs0   (m1_rs0),
        .m1_wdata (m1_wdata),
        .m1_lock  (m1_lock),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .bus_sel  (bus_sel),
        .bus_we_n (bus_we_n),
        .bus_a    (bus_a),
        .bus_rs0  (bus_rs0),
        .bus_di   (bus_di),
        .bus_do   (bus_do)
    );

    rriot_bus_arbiter #(
        .ACCESS_CYCLES (3),
        .MAX_LOCK      (4)
    ) dut3 (
        .phi2     (phi2),
        .rst_n    (rst_n),
        .m0_req   (t_req),
        .m0_we    (t_we),
        .m0_addr  (t_addr),
        .m0_rs0   (t_rs0),
        .m0_wdata (8'h00),
        .m0_lock  (1'b0),
        .m0_ack   (t_m0_ack),
        .m0_rdata (t_m0_rdata),
        .m1_req   (1'b0),
        .m1_we    (1'b0),
        .m1_addr  (10'h000),
        .m1_rs0   (1'b0),
        .m1_wdata (8'h00),
        .m1_lock  (1'b0),
        .m1_ack   (t_m1_ack),
        .m1_rdata (t_m1_rdata),
        .bus_sel  (t_sel),
        .bus_we_n (t_we_n),
        .bus_a    (t_a),
        .bus_rs0  (t_bus_rs0),
        .bus_di   (t_di),
        .bus_do   (t_do)
    );

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge phi2);
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [9:0] addr,
                          input logic rs0, input logic [7:0] wdata, input logic lock);
        m0_req = req; m0_we = we; m0_addr = addr; m0_rs0 = rs0; m0_wdata = wdata; m0_lock = lock;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [9:0] addr,
                          input logic rs0, input logic [7:0] wdata, input logic lock);
        m1_req = req; m1_we = we; m1_addr = addr; m1_rs0 = rs0; m1_wdata = wdata; m1_lock = lock;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_m0(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        set_m1(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        bus_do = 8'h00;
        t_req = 1'b0; t_we = 1'b0; t_addr = 10'h000; t_rs0 = 1'b0; t_do = 8'h00;
        repeat (2) cyc();
        rst_n = 1'b1;

        // Reset values
        check("rst_bus_sel", bus_sel, 1'b0);
        check("rst_bus_we_n", bus_we_n, 1'b1);
        check("rst_bus_a", bus_a, 10'h000);
        check("rst_bus_rs0", bus_rs0, 1'b0);
        check("rst_bus_di", bus_di, 8'h00);
        check("rst_acks", {m0_ack, m1_ack}, 2'b00);
        check("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);

        // Single m0 read of 0x380 / RS0=1
        set_m0(1'b1, 1'b0, 10'h380, 1'b1, 8'hEE, 1'b0);
        bus_do = 8'h5A;
        cyc();
        check("rd_sel", bus_sel, 1'b1);
        check("rd_we_n", bus_we_n, 1'b1);
        check("rd_a", bus_a, 10'h380);
        check("rd_rs0", bus_rs0, 1'b1);
        check("rd_di", bus_di, 8'h00);
        check("rd_ack_early", m0_ack, 1'b0);
        cyc();
        check("rd_ack", m0_ack, 1'b1);
        check("rd_rdata", m0_rdata, 8'h5A);
        check("rd_m1_ack", m1_ack, 1'b0);
        check("rd_resp_sel", bus_sel, 1'b0);
        set_m0(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        bus_do = 8'h00;
        cyc();
        check("rd_ack_once", m0_ack, 1'b0);
        check("rd_rdata_hold", m0_rdata, 8'h5A);

        // ACCESS_CYCLES=3 read of 0x3FF
        t_req = 1'b1; t_addr = 10'h3FF; t_do = 8'h01;
        cyc();
        check("ac3_sel_c1", t_sel, 1'b1);
        check("ac3_a", t_a, 10'h3FF);
        t_do = 8'h02;
        cyc();
        check("ac3_sel_c2", t_sel, 1'b1);
        check("ac3_ack_c2", t_m0_ack, 1'b0);
        t_do = 8'hC3;
        cyc();
        check("ac3_sel_c3", t_sel, 1'b1);
        check("ac3_ack_c3", t_m0_ack, 1'b0);
        cyc();
        check("ac3_sel_c4", t_sel, 1'b0);
        check("ac3_ack_c4", t_m0_ack, 1'b1);
        check("ac3_rdata", t_m0_rdata, 8'hC3);
        t_req = 1'b0; t_do = 8'h77;
        cyc();
        check("ac3_ack_once", t_m0_ack, 1'b0);
        check("ac3_rdata_hold", t_m0_rdata, 8'hC3);

        // Tie from reset: m0 first, then m1
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus_do = 8'hA5;
        set_m0(1'b1, 1'b1, 10'h000, 1'b0, 8'h11, 1'b0);
        set_m1(1'b1, 1'b1, 10'h001, 1'b0, 8'h22, 1'b0);
        cyc();
        check("tie_di0", bus_di, 8'h11);
        check("tie_a0", bus_a, 10'h000);
        check("tie_we_n0", bus_we_n, 1'b0);
        cyc();
        check("tie_acks0", {m1_ack, m0_ack}, 2'b01);
        check("tie_wr_rdata", m0_rdata, 8'h00);
        set_m0(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();
        check("tie_idle_sel", bus_sel, 1'b0);
        cyc();
        check("tie_di1", bus_di, 8'h22);
        check("tie_a1", bus_a, 10'h001);
        cyc();
        check("tie_acks1", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();

        // Lock: m1 holds the grant for three writes against a waiting m0
        set_m1(1'b1, 1'b1, 10'h010, 1'b0, 8'h31, 1'b1);
        cyc();
        check("lk_di1", bus_di, 8'h31);
        set_m0(1'b1, 1'b1, 10'h020, 1'b0, 8'h44, 1'b0);
        cyc();
        check("lk_ack1", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b1, 1'b1, 10'h011, 1'b0, 8'h32, 1'b1);
        cyc();
        cyc();
        check("lk_di2", bus_di, 8'h32);
        cyc();
        check("lk_ack2", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b1, 1'b1, 10'h012, 1'b0, 8'h33, 1'b0);
        cyc();
        cyc();
        check("lk_di3", bus_di, 8'h33);
        cyc();
        check("lk_ack3", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b1, 1'b1, 10'h013, 1'b0, 8'h34, 1'b0);
        cyc();
        cyc();
        check("lk_m0_di", bus_di, 8'h44);
        check("lk_m0_a", bus_a, 10'h020);
        cyc();
        check("lk_m0_ack", {m1_ack, m0_ack}, 2'b01);
        set_m0(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();
        cyc();
        check("lk_m1_di4", bus_di, 8'h34);
        cyc();
        check("lk_m1_ack4", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();

        // Lock cap: four locked m0 grants, then m1 gets through
        set_m1(1'b1, 1'b1, 10'h030, 1'b0, 8'h66, 1'b0);
        set_m0(1'b1, 1'b1, 10'h040, 1'b0, 8'h50, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("cap_di%0d", k), bus_di, 32'h50 + k);
            cyc();
            check($sformatf("cap_ack%0d", k), {m1_ack, m0_ack}, 2'b01);
            m0_wdata = 8'(8'h51 + k);
            cyc();
        end
        cyc();
        check("cap_m1_di", bus_di, 8'h66);
        check("cap_m1_a", bus_a, 10'h030);
        cyc();
        check("cap_m1_ack", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();
        cyc();
        check("cap_m0_again", bus_di, 8'h54);
        cyc();
        check("cap_m0_ack", {m1_ack, m0_ack}, 2'b01);
        set_m0(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();

        // Async reset in the middle of an m0 read
        set_m0(1'b1, 1'b0, 10'h100, 1'b0, 8'h00, 1'b0);
        cyc();
        check("ar_pre_a", bus_a, 10'h100);
        check("ar_pre_sel", bus_sel, 1'b1);
        rst_n = 1'b0;
        set_m0(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        set_m1(1'b1, 1'b1, 10'h200, 1'b0, 8'h99, 1'b0);
        #1;
        check("ar_sel", bus_sel, 1'b0);
        check("ar_we_n", bus_we_n, 1'b1);
        check("ar_a", bus_a, 10'h000);
        #3;
        rst_n = 1'b1;
        cyc();
        check("ar_no_ack", m0_ack, 1'b0);
        check("ar_m1_a", bus_a, 10'h200);
        check("ar_m1_di", bus_di, 8'h99);
        check("ar_m1_we_n", bus_we_n, 1'b0);
        cyc();
        check("ar_m1_ack", {m1_ack, m0_ack}, 2'b10);
        set_m1(1'b0, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0);
        cyc();
        check("ar_end_sel", bus_sel, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
